// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, FSM state enum and stage payload structs for the EX/MEM/WB pipe.
// Rev 1.0
`default_nettype none

package pipe_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_to_reg;
      logic              mem_read;
      logic              mem_write;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   alu_result;
      logic [XLEN-1:0]   store_data;
   } ex_mem_t;

   typedef struct packed {
      logic              reg_write;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   write_data;
   } mem_wb_t;

   // x0 is hardwired to zero, so a write to it is never a real write.
   function automatic logic rd_writes(input logic we, input logic [REG_AW-1:0] rd);
      return we && (rd != '0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: data-memory wait tracker producing the pipeline stall (Rev 1.0).
// Optional stall counter enabled by MEM_STALL_CNT_EN.
`default_nettype none

module mem_wait_fsm
   import pipe_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_op,
   input  logic        dmem_ready_i,
   output logic        stall,
   output state_t      state
`ifdef MEM_STALL_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt
`endif
);

   state_t next_state;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Ready is used combinationally so a zero-wait memory never stalls.
   always_comb begin
      next_state = state;
      stall      = mem_op && !dmem_ready_i;
      case (state)
         IDLE:    if (stall)        next_state = WAIT;
         WAIT:    if (dmem_ready_i) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

`ifdef MEM_STALL_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_stall_cnt <= '0;
      end else if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/ex_mem_wb_pipe.sv
// ex_mem_wb_pipe: EX/MEM and MEM/WB pipeline registers with variable-latency dmem handshake (Rev 1.0).
// Define MEM_STALL_CNT_EN to add the perf_stall_cnt_o stall counter.
`default_nettype none

module ex_mem_wb_pipe
   import pipe_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ex_RegWrite_i,
   input  logic              ex_MemToReg_i,
   input  logic              ex_MemRead_i,
   input  logic              ex_MemWrite_i,
   input  logic [REG_AW-1:0] ex_Rd_i,
   input  logic [XLEN-1:0]   ex_ALUResult_i,
   input  logic [XLEN-1:0]   ex_StoreData_i,
   output logic              stall_o,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [XLEN-1:0]   dmem_addr_o,
   output logic [XLEN-1:0]   dmem_wdata_o,
   input  logic              dmem_ready_i,
   input  logic [XLEN-1:0]   dmem_rdata_i,
   output logic              RegWrite_p_o,
   output logic [REG_AW-1:0] Rd_p_o,
   output logic [XLEN-1:0]   Result_p_o,
   output logic              RegWrite_pp_o,
   output logic [REG_AW-1:0] Rd_pp_o,
   output logic [XLEN-1:0]   WriteData_pp_o
`ifdef MEM_STALL_CNT_EN
   ,
   output logic [31:0]       perf_stall_cnt_o
`endif
);

   ex_mem_t ex_mem_q;
   ex_mem_t ex_mem_d;
   mem_wb_t mem_wb_q;
   mem_wb_t mem_wb_d;
   logic    mem_op;
   logic    stall;
   state_t  state;

   // Store wins over a conflicting load, and a store never writes a register.
   always_comb begin
      ex_mem_d            = '0;
      ex_mem_d.valid      = 1'b1;
      ex_mem_d.reg_write  = ex_RegWrite_i && !ex_MemWrite_i;
      ex_mem_d.mem_to_reg = ex_MemToReg_i;
      ex_mem_d.mem_read   = ex_MemRead_i && !ex_MemWrite_i;
      ex_mem_d.mem_write  = ex_MemWrite_i;
      ex_mem_d.rd         = ex_Rd_i;
      ex_mem_d.alu_result = ex_ALUResult_i;
      ex_mem_d.store_data = ex_StoreData_i;
   end

   assign mem_op = ex_mem_q.valid && (ex_mem_q.mem_read || ex_mem_q.mem_write);

   always_comb begin
      mem_wb_d            = '0;
      mem_wb_d.reg_write  = ex_mem_q.valid && rd_writes(ex_mem_q.reg_write, ex_mem_q.rd);
      mem_wb_d.rd         = ex_mem_q.rd;
      mem_wb_d.write_data = ex_mem_q.mem_to_reg ? dmem_rdata_i : ex_mem_q.alu_result;
   end

   mem_wait_fsm u_fsm (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .mem_op         (mem_op),
      .dmem_ready_i   (dmem_ready_i),
      .stall          (stall),
      .state          (state)
`ifdef MEM_STALL_CNT_EN
      ,
      .perf_stall_cnt (perf_stall_cnt_o)
`endif
   );

   // While stalled EX/MEM holds its request and MEM/WB takes a bubble.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_mem_q <= '0;
         mem_wb_q <= '0;
      end else if (stall) begin
         mem_wb_q <= '0;
      end else begin
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   assign stall_o        = stall;
   assign dmem_req_o     = mem_op;
   assign dmem_we_o      = mem_op && ex_mem_q.mem_write;
   assign dmem_addr_o    = ex_mem_q.alu_result;
   assign dmem_wdata_o   = ex_mem_q.store_data;

   assign RegWrite_p_o   = ex_mem_q.valid && rd_writes(ex_mem_q.reg_write, ex_mem_q.rd);
   assign Rd_p_o         = ex_mem_q.rd;
   assign Result_p_o     = ex_mem_q.alu_result;

   assign RegWrite_pp_o  = rd_writes(mem_wb_q.reg_write, mem_wb_q.rd);
   assign Rd_pp_o        = mem_wb_q.rd;
   assign WriteData_pp_o = mem_wb_q.write_data;

   // A pending request is never withdrawn while waiting.
   a_req_held : assert property (@(posedge clk_i) disable iff (rst_i) (state == WAIT) |-> mem_op);

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_wb_pipe.sv
// tb_ex_mem_wb_pipe: scoreboard bench for ex_mem_wb_pipe with a variable-wait memory model.
// Define MEM_STALL_CNT_EN to also check perf_stall_cnt_o.
`default_nettype none
`timescale 1ns/1ps

module tb_ex_mem_wb_pipe;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_rw = 1'b0, ex_m2r = 1'b0, ex_mr = 1'b0, ex_mw = 1'b0;
   logic [4:0]  ex_rd = '0;
   logic [31:0] ex_alu = '0, ex_sd = '0;
   logic        dmem_ready = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        stall, req, we, rw_p, rw_pp;
   logic [31:0] addr, wdata, res_p, wd_pp;
   logic [4:0]  rd_p, rd_pp;
`ifdef MEM_STALL_CNT_EN
   logic [31:0] perf_cnt;
`endif

   always #5 clk = ~clk;

   ex_mem_wb_pipe dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ex_RegWrite_i  (ex_rw),
      .ex_MemToReg_i  (ex_m2r),
      .ex_MemRead_i   (ex_mr),
      .ex_MemWrite_i  (ex_mw),
      .ex_Rd_i        (ex_rd),
      .ex_ALUResult_i (ex_alu),
      .ex_StoreData_i (ex_sd),
      .stall_o        (stall),
      .dmem_req_o     (req),
      .dmem_we_o      (we),
      .dmem_addr_o    (addr),
      .dmem_wdata_o   (wdata),
      .dmem_ready_i   (dmem_ready),
      .dmem_rdata_i   (dmem_rdata),
      .RegWrite_p_o   (rw_p),
      .Rd_p_o         (rd_p),
      .Result_p_o     (res_p),
      .RegWrite_pp_o  (rw_pp),
      .Rd_pp_o        (rd_pp),
      .WriteData_pp_o (wd_pp)
`ifdef MEM_STALL_CNT_EN
      ,
      .perf_stall_cnt_o (perf_cnt)
`endif
   );

   typedef struct {
      logic        rw, m2r, mr, mw;
      logic [4:0]  rd;
      logic [31:0] alu, sd, ld;
      int          waits;
   } instr_t;

   typedef struct packed {
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   instr_t prog[$];
   wb_t    wb_q[$];
   int     vectors     = 0;
   int     miscompares = 0;
   int     stall_total = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic instr_t mk(input logic rw, m2r, mr, mw, input logic [4:0] rd,
                                 input logic [31:0] alu, sd, ld, input int waits);
      instr_t i;
      i.rw = rw; i.m2r = m2r; i.mr = mr; i.mw = mw; i.rd = rd;
      i.alu = alu; i.sd = sd; i.ld = ld; i.waits = waits;
      return i;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, ".stall"}, 64'(stall), 64'd0);
      check({tag, ".req"},   64'(req),   64'd0);
      check({tag, ".we"},    64'(we),    64'd0);
      check({tag, ".addr"},  64'(addr),  64'd0);
      check({tag, ".wdata"}, 64'(wdata), 64'd0);
      check({tag, ".p"},     {26'd0, rw_p, rd_p, res_p}, 64'd0);
      check({tag, ".pp"},    {26'd0, rw_pp, rd_pp, wd_pp}, 64'd0);
      check({tag, ".state"}, 64'(dut.u_fsm.state), 64'(IDLE));
`ifdef MEM_STALL_CNT_EN
      check({tag, ".perf"},  64'(perf_cnt), 64'd0);
`endif
   endtask

   // Asserts reset asynchronously mid-cycle, checks it took effect at once, releases on a negedge.
   task automatic pulse_reset(input string tag);
      #2 rst = 1'b1;
      {ex_rw, ex_m2r, ex_mr, ex_mw, ex_rd, ex_alu, ex_sd} = '0;
      dmem_ready = 1'b0;
      #1 check_all_zero(tag);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      stall_total = 0;
      wb_q.delete();
      wb_q.push_back('0);
   endtask

   // Cycle loop: drive upstream, model memory, compare, then advance the model one edge.
   task automatic run_prog(input string tag, input int abort_stall);
      instr_t nop, cur, exm;
      wb_t    exp_wb, got_wb;
      logic   memop, exp_stall;
      int     pc = 0, waits_left = 0, stalls_seen = 0;
      nop = mk(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0);
      exm = nop;
      while (pc < prog.size()) begin
         @(negedge clk);
         cur = prog[pc];
         {ex_rw, ex_m2r, ex_mr, ex_mw} = {cur.rw, cur.m2r, cur.mr, cur.mw};
         ex_rd = cur.rd; ex_alu = cur.alu; ex_sd = cur.sd;
         memop      = exm.mr || exm.mw;
         exp_stall  = memop && (waits_left > 0);
         dmem_ready = memop ? !exp_stall : 1'($urandom_range(0, 1));
         dmem_rdata = memop ? exm.ld : $urandom;
         #1;
         check({tag, ".stall"}, 64'(stall), 64'(exp_stall));
         check({tag, ".req"},   64'(req),   64'(memop));
         check({tag, ".we"},    64'(we),    64'(memop && exm.mw));
         check({tag, ".addr"},  64'(addr),  64'(exm.alu));
         check({tag, ".wdata"}, 64'(wdata), 64'(exm.sd));
         check({tag, ".p"}, {26'd0, rw_p, rd_p, res_p},
               {26'd0, exm.rw && !exm.mw && (exm.rd != 5'd0), exm.rd, exm.alu});
         got_wb = {rw_pp, rd_pp, wd_pp};
         if (wb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd1, 64'd0);
         end else begin
            exp_wb = wb_q.pop_front();
            check({tag, ".pp"}, 64'(got_wb), 64'(exp_wb));
         end
         if (exp_stall) begin
            stalls_seen++;
            if (stalls_seen == abort_stall) begin
               pulse_reset({tag, ".abort"});
               return;
            end
            waits_left--;
            stall_total++;
            wb_q.push_back('0);
         end else begin
            exp_wb.rw   = exm.rw && !exm.mw && (exm.rd != 5'd0);
            exp_wb.rd   = exm.rd;
            exp_wb.data = exm.m2r ? exm.ld : exm.alu;
            wb_q.push_back(exp_wb);
            exm        = cur;
            waits_left = cur.waits;
            pc++;
         end
      end
`ifdef MEM_STALL_CNT_EN
      @(negedge clk);
      check({tag, ".perf"}, 64'(perf_cnt), 64'(stall_total));
`endif
   endtask

   task automatic add_nops(input int n);
      for (int i = 0; i < n; i++) prog.push_back(mk(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 0));
   endtask

   initial begin
      pulse_reset("reset");

      // Mixed program: ALU, waited load, zero-wait store, x0 write, back-to-back loads.
      prog.delete();
      prog.push_back(mk(1, 0, 0, 0, 5'd5,  32'h10,       32'h0,    32'h0,        0));
      prog.push_back(mk(1, 1, 1, 0, 5'd7,  32'h40,       32'h0,    32'hDEADBEEF, 3));
      prog.push_back(mk(1, 0, 0, 1, 5'd3,  32'h80,       32'h1234, 32'h0,        0));
      prog.push_back(mk(1, 0, 0, 0, 5'd0,  32'h55,       32'h0,    32'h0,        0));
      prog.push_back(mk(1, 1, 1, 0, 5'd9,  32'h44,       32'h0,    32'hCAFE0009, 0));
      prog.push_back(mk(1, 1, 1, 0, 5'd10, 32'h48,       32'h0,    32'hCAFE000A, 2));
      prog.push_back(mk(1, 1, 1, 0, 5'd11, 32'h4C,       32'h0,    32'hCAFE000B, 4));
      prog.push_back(mk(1, 0, 1, 1, 5'd12, 32'h90,       32'hABCD, 32'h0,        1));
      prog.push_back(mk(1, 0, 0, 0, 5'd31, 32'hFFFFFFFF, 32'h0,    32'h0,        0));
      add_nops(3);
      run_prog("mix", 0);

      // Reset in the second wait cycle of a load abandons it.
      pulse_reset("reset2");
      prog.delete();
      prog.push_back(mk(1, 1, 1, 0, 5'd7, 32'h40, 32'h0, 32'h0BADC0DE, 5));
      add_nops(3);
      run_prog("abort", 2);
      prog.delete();
      add_nops(5);
      run_prog("post_abort", 0);

      // Two loads with 2 and 4 wait cycles.
      pulse_reset("reset3");
      prog.delete();
      prog.push_back(mk(1, 1, 1, 0, 5'd1, 32'h100, 32'h0, 32'h11111111, 2));
      prog.push_back(mk(1, 1, 1, 0, 5'd2, 32'h104, 32'h0, 32'h22222222, 4));
      add_nops(3);
      run_prog("two_loads", 0);
      check("two_loads.stalls", 64'(stall_total), 64'd6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/ex_mem_wb_pipe.md
# ex_mem_wb_pipe

Two-deep pipeline-register block holding the EX/MEM and MEM/WB stages of the 5-stage RISC-V core, with a variable-latency data-memory handshake. It produces the RegWrite/Rd pairs for the previous and pre-previous instruction that the forwarding logic compares against Rs1/Rs2, plus the forwardable EX/MEM result and the final write-back data for the register file. It asserts a pipeline stall while a load or store is waiting on the memory.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register-address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- ex_RegWrite_i, ex_MemToReg_i, ex_MemRead_i, ex_MemWrite_i  in  1 each  control bits from ID/EX
- ex_Rd_i  in  REG_AW  destination register
- ex_ALUResult_i  in  XLEN  ALU result, also the memory address
- ex_StoreData_i  in  XLEN  forwarded rs2 value for stores
- stall_o  out  1  hold PC, IF/ID and ID/EX; upstream keeps ex_* stable
- dmem_req_o, dmem_we_o  out  1 each  memory request / write enable
- dmem_addr_o, dmem_wdata_o  out  XLEN  address / store data
- dmem_ready_i  in  1  request completes this cycle
- dmem_rdata_i  in  XLEN  load data, valid with ready
- RegWrite_p_o, Rd_p_o, Result_p_o  out  1/REG_AW/XLEN  EX/MEM stage
- RegWrite_pp_o, Rd_pp_o, WriteData_pp_o  out  1/REG_AW/XLEN  MEM/WB stage, to register file and forwarding

## Operation
- FSM states IDLE, WAIT. mem_op = EX/MEM valid and (MemRead or MemWrite).
- dmem_req_o = mem_op in either state; addr/wdata/we driven from EX/MEM registers, so they stay stable while waiting.
- stall_o = mem_op and not dmem_ready_i. The ready check is combinational, so a zero-wait memory never stalls.
- IDLE -> WAIT when mem_op and not ready. WAIT -> IDLE on ready. Non-mem ops stay in IDLE.
- Each cycle without stall:
  - EX/MEM loads ex_*.
  - MEM/WB loads EX/MEM.
  - WriteData_pp = dmem_rdata_i if MemToReg, else the ALU result.
- Each cycle with stall:
  - EX/MEM holds.
  - MEM/WB loads a bubble (RegWrite 0, Rd 0, data 0).
- Register x0 rule: RegWrite_p_o and RegWrite_pp_o are forced 0 whenever the stage's Rd is 0. Downstream comparators therefore need no x0 check.
- MemRead and MemWrite both set is illegal; MemWrite wins and MemRead is ignored.
- Stores never set RegWrite, regardless of ex_RegWrite_i.

## Timing
- Reset (asynchronous) values:
  - All stage registers and all outputs are 0.
  - State is IDLE.
  - dmem_req_o and stall_o drop in the same instant as rst_i asserts.
- Reset during WAIT abandons the access. No retry follows reset.
- Latency: ex_* to *_p_o is 1 cycle; to *_pp_o is 2 cycles plus N wait cycles.
- Memory handshake rules:
  - The memory samples a request on any edge where req and ready are both high.
  - Ready without req is ignored.
  - Req is never withdrawn before ready, except by reset.
- Back-to-back memory ops: the second is presented in the cycle after the first completes. No idle cycle is inserted.

## Configuration
- MEM_STALL_CNT_EN defined:
  - Adds output perf_stall_cnt_o (32-bit).
  - Increments on each cycle with stall_o high.
  - Saturates at 0xFFFF_FFFF and resets to 0.
- Undefined: the port and the counter are absent.

## Structure
- Shared package pipe_pkg holds:
  - XLEN, REG_AW
  - the state enum {IDLE, WAIT}
  - the EX/MEM payload struct (ctrl bits, Rd, ALU result, store data)
  - the MEM/WB payload struct (RegWrite, Rd, write data)
- One sub-module, mem_wait_fsm:
  - Inputs: mem_op, dmem_ready_i.
  - Outputs: stall and state, plus the optional counter.
  - The stage registers stay in the top module.

## Test plan
- ALU op, ex_Rd_i=5, RegWrite=1, result 0x10, no memory -> Rd_p_o=5 and Result_p_o=0x10 after 1 cycle; Rd_pp_o=5 and WriteData_pp_o=0x10 after 2 cycles; stall_o never high.
- Load to x7 at addr 0x40, dmem_ready_i low for 3 cycles, rdata 0xDEADBEEF -> stall_o high for exactly 3 cycles with addr held at 0x40; three bubbles (RegWrite_pp_o=0); then Rd_pp_o=7 and WriteData_pp_o=0xDEADBEEF.
- Store 0x1234 to 0x80 with zero-wait ready -> dmem_we_o=1 for 1 cycle, stall_o low, RegWrite_pp_o=0.
- ALU op writing x0 with RegWrite=1 -> RegWrite_p_o and RegWrite_pp_o stay 0.
- rst_i pulsed in the 2nd WAIT cycle -> dmem_req_o, stall_o and all outputs 0 immediately; state IDLE; no write-back of the aborted load.
- MEM_STALL_CNT_EN defined, two loads with 2 and 4 wait cycles -> perf_stall_cnt_o=6.
